// File: rtl/cmd_stream_decoder.sv
// cmd_stream_decoder
//   Consumes the line-oriented simulation control stream one byte per character
//   and drives the CPU UART receive port. Commands (first byte of a line):
//     '/' comment, 'r' forward payload to rx, 't N' wait for N transmitted chars,
//     '# N' wait N clocks, 'q' quit. '\r' is discarded wherever input is accepted.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   in_data    command stream byte
//   in_valid   in_data valid
//   in_ready   byte accepted when in_valid && in_ready
//   rx_data    byte to the CPU UART receive port (registered)
//   rx_valid   rx_data valid (registered)
//   rx_ready   CPU consumes the rx byte when rx_valid && rx_ready
//   tx_strobe  one-cycle pulse per character transmitted by the CPU
//   busy       high while waiting on a 't' or '#' command
//   done       high once 'q' has been seen, until reset
//   err        sticky error flag, cleared only by reset
module cmd_stream_decoder #(
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned RX_APPEND_NL = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic       tx_strobe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // acc*10 + digit never needs more than four extra bits
   localparam int unsigned AccW = CNT_WIDTH + 4;

   localparam logic [7:0] ChNl    = 8'h0a;
   localparam logic [7:0] ChCr    = 8'h0d;
   localparam logic [7:0] ChSpace = 8'h20;
   localparam logic [7:0] ChHash  = 8'h23;
   localparam logic [7:0] ChSlash = 8'h2f;
   localparam logic [7:0] ChQ     = 8'h71;
   localparam logic [7:0] ChR     = 8'h72;
   localparam logic [7:0] ChT     = 8'h74;

   typedef enum logic [2:0] {
      StIdle,
      StComment,
      StRxPass,
      StNum,
      StTxWait,
      StDelay,
      StQuit
   } state_e;

   state_e state_q, state_d;

   logic [CNT_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 cmd_delay_q;   // latched command: 1 = '#', 0 = 't'
   logic [7:0]           rx_data_q;
   logic                 rx_valid_q;
   logic                 err_q;

   logic                 accept;
   logic                 is_nl, is_cr, is_space, is_digit;
   logic                 idle_known, num_bad, err_set;
   logic [AccW-1:0]      acc_mul;
   logic [CNT_WIDTH-1:0] acc_next;
   logic                 cnt_last;
   logic                 rx_load;

   // Byte classification and datapath helpers
   always_comb begin
      accept     = in_valid && in_ready;
      is_nl      = (in_data == ChNl);
      is_cr      = (in_data == ChCr);
      is_space   = (in_data == ChSpace);
      is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
      idle_known = is_nl || is_cr || (in_data inside {ChSlash, ChR, ChT, ChHash, ChQ});
      num_bad    = !(is_digit || is_space || is_cr || is_nl);
      // low nibble of an ASCII digit is its value
      acc_mul    = AccW'(acc_q) * AccW'(10) + AccW'(in_data[3:0]);
      acc_next   = (acc_mul[AccW-1:CNT_WIDTH] != '0) ? '1 : acc_mul[CNT_WIDTH-1:0];
      cnt_last   = (cnt_q == CNT_WIDTH'(1));
      rx_load    = accept && (state_q == StRxPass) && !is_cr &&
                   (!is_nl || (RX_APPEND_NL != 0));
      err_set    = (tx_strobe && (state_q != StTxWait)) ||
                   (accept && (state_q == StIdle) && !idle_known) ||
                   (accept && (state_q == StNum) && num_bad);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_data == ChSlash)                          state_d = StComment;
               else if (in_data == ChR)                         state_d = StRxPass;
               else if ((in_data == ChT) || (in_data == ChHash)) state_d = StNum;
               else if (in_data == ChQ)                         state_d = StQuit;
               else if (!idle_known)                            state_d = StComment;
            end
         end
         StComment: if (accept && is_nl) state_d = StIdle;
         StRxPass:  if (accept && is_nl) state_d = StIdle;
         StNum: begin
            if (accept) begin
               if (is_nl) begin
                  if (acc_q == '0)      state_d = StIdle;
                  else if (cmd_delay_q) state_d = StDelay;
                  else                  state_d = StTxWait;
               end else if (num_bad) begin
                  state_d = StComment;
               end
            end
         end
         StTxWait: if (tx_strobe && cnt_last) state_d = StIdle;
         StDelay:  if (cnt_last) state_d = StIdle;
         StQuit:   state_d = StQuit;
         default:  state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle, StComment, StNum: in_ready = 1'b1;
         // one-byte holding register with full throughput
         StRxPass:                 in_ready = !rx_valid_q || rx_ready;
         StTxWait, StDelay:        busy     = 1'b1;
         StQuit:                   done     = 1'b1;
         default:                  in_ready = 1'b0;
      endcase
   end

   // Datapath: argument accumulator, wait counter, rx stage, error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         cmd_delay_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (err_set) err_q <= 1'b1;

         if (accept && (state_q == StIdle) && ((in_data == ChT) || (in_data == ChHash))) begin
            cmd_delay_q <= (in_data == ChHash);
            acc_q       <= '0;
         end

         if (accept && (state_q == StNum)) begin
            if (is_digit)   acc_q <= acc_next;
            else if (is_nl) cnt_q <= acc_q;
         end

         if (((state_q == StTxWait) && tx_strobe) || (state_q == StDelay)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end

         // rx stage keeps draining in every state, including after a 'q'
         if (rx_load) begin
            rx_data_q  <= in_data;
            rx_valid_q <= 1'b1;
         end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign err      = err_q;

endmodule

// File: tb/tb_cmd_stream_decoder.sv
// Testbench for cmd_stream_decoder: directed scenarios followed by random
// command lines, checked against a line-level reference model.
module tb_cmd_stream_decoder;

   localparam int unsigned CntW = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       tx_strobe;
   logic       busy;
   logic       done;
   logic       err;

   always #5 clk = ~clk;

   cmd_stream_decoder #(
      .CNT_WIDTH   (CntW),
      .RX_APPEND_NL(0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_strobe(tx_strobe),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] got_rx[$];
   bit         err_m;
   int         ready_mode = 0;  // 0 random, 1 hold low, 2 hold high
   bit         mon_stall = 1'b0;
   logic [7:0] mon_held = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // CPU receive side
   initial begin
      rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       rx_ready = 1'($urandom_range(0, 1));
            1:       rx_ready = 1'b0;
            default: rx_ready = 1'b1;
         endcase
      end
   end

   // Collect consumed rx bytes; a stalled byte must stay put
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_stall) check_eq("rx_hold", {rx_valid, rx_data}, {1'b1, mon_held});
         mon_stall = 1'b0;
         if (!reset) begin
            if (rx_valid && rx_ready) got_rx.push_back(rx_data);
            if (rx_valid && !rx_ready) begin
               mon_stall = 1'b1;
               mon_held  = rx_data;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Called just after a negedge; returns at the negedge following acceptance.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      in_data  = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         check_eq("accept_timeout", 32'(waited), 0);
         in_valid = 1'b0;
         @(negedge clk);
      end else begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      tx_strobe = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_rx.delete();
      got_rx.delete();
      err_m = 1'b0;
   endtask

   // Line-level reference: expected rx bytes, error, and wait (kind 1 tx, 2 delay)
   task automatic model_line(input string s, output int kind, output int n);
      logic [7:0] c;
      logic [7:0] c2;
      longint     v;
      longint     vmax;
      bit         bad;
      kind = 0;
      n    = 0;
      vmax = (longint'(1) << CntW) - 1;
      c    = s[0];
      if (c == "r") begin
         for (int i = 1; i < s.len(); i++) begin
            c2 = s[i];
            if (c2 != 8'h0a && c2 != 8'h0d) exp_rx.push_back(c2);
         end
      end else if (c == "t" || c == "#") begin
         v   = 0;
         bad = 1'b0;
         for (int i = 1; i < s.len(); i++) begin
            c2 = s[i];
            if (c2 == 8'h0a) break;
            if (c2 == " " || c2 == 8'h0d) continue;
            if (c2 >= "0" && c2 <= "9") begin
               v = v * 10 + longint'(c2 - 8'h30);
               if (v > vmax) v = vmax;
            end else begin
               bad = 1'b1;
               break;
            end
         end
         if (bad) err_m = 1'b1;
         else if (v != 0) begin
            kind = (c == "t") ? 1 : 2;
            n    = int'(v);
         end
      end else if (c != "q" && c != "/" && c != 8'h0a) begin
         err_m = 1'b1;
      end
   endtask

   task automatic run_line(input string s);
      int         kind;
      int         n;
      int         w;
      logic [7:0] ch;
      logic [7:0] c0;
      model_line(s, kind, n);
      c0 = s[0];
      for (int i = 0; i < s.len(); i++) begin
         ch = s[i];
         send_byte(ch);
         if (c0 == "r" && i > 0 && ch != 8'h0a && ch != 8'h0d) begin
            #1;
            check_eq("rx_latency", {rx_valid, rx_data}, {1'b1, ch});
         end
      end
      #1;
      if (kind == 2) begin
         w = 0;
         while (busy && w < n + 20) begin
            @(negedge clk);
            #1;
            w++;
         end
         check_eq("delay_len", w, n);
         check_eq("delay_exit_ready", in_ready, 1);
      end else if (kind == 1) begin
         for (int j = 1; j <= n; j++) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               #1;
            end
            check_eq("tx_busy", busy, 1);
            tx_strobe = 1'b1;
            @(negedge clk);
            tx_strobe = 1'b0;
            #1;
         end
         check_eq("tx_exit", {busy, in_ready}, 2'b01);
      end else if (c0 == "t" || c0 == "#") begin
         check_eq("no_wait", busy, 0);
      end
      check_eq("err", err, err_m);
      @(negedge clk);
   endtask

   task automatic drain_and_compare(input string tag);
      int w = 0;
      #3;
      while (rx_valid && w < 100) begin
         @(negedge clk);
         #3;
         w++;
      end
      check_eq({tag, "_count"}, got_rx.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
         check_eq({tag, "_byte"}, got_rx[i], exp_rx[i]);
      end
      exp_rx.delete();
      got_rx.delete();
      @(negedge clk);
   endtask

   function automatic string rand_line();
      string s;
      int    k;
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: begin
            s = "r";
            repeat ($urandom_range(0, 6)) begin
               if ($urandom_range(0, 7) == 0) s = $sformatf("%s%c", s, 8'h0d);
               else s = $sformatf("%s%c", s, 8'($urandom_range(33, 126)));
            end
            s = $sformatf("%s\n", s);
         end
         3, 4: begin
            if ($urandom_range(0, 1) == 1) s = $sformatf("# %0d\n", $urandom_range(0, 20));
            else s = $sformatf("#%0d\n", $urandom_range(0, 20));
         end
         5, 6: begin
            if ($urandom_range(0, 1) == 1) s = $sformatf("t %0d%c\n", $urandom_range(0, 4), 8'h0d);
            else s = $sformatf("t%0d\n", $urandom_range(0, 4));
         end
         7:       s = "/note x\n";
         8:       s = "\n";
         default: s = ($urandom_range(0, 1) == 1) ? "x9\n" : "#1z\n";
      endcase
      return s;
   endfunction

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      tx_strobe = 1'b0;
      err_m     = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      @(negedge clk);

      // plain forwarding, no trailing newline
      ready_mode = 2;
      @(negedge clk);
      run_line("rHI\n");
      drain_and_compare("rhi");

      // receiver stalls with a byte held
      ready_mode = 1;
      @(negedge clk);
      send_byte("r");
      send_byte("A");
      #1;
      check_eq("stall_first", {rx_valid, rx_data}, {1'b1, 8'h41});
      exp_rx.push_back("A");
      exp_rx.push_back("B");
      in_data  = "B";
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         check_eq("stall_ready", in_ready, 0);
         check_eq("stall_data", rx_data, 8'h41);
      end
      ready_mode = 2;
      send_byte("B");
      send_byte(8'h0a);
      drain_and_compare("stall");

      // clock delay then quit
      run_line("#5\n");
      send_byte("q");
      #1;
      check_eq("quit_done", {done, in_ready}, 2'b10);
      do_reset();

      // transmit wait
      run_line("t 3\n");

      // lines that do nothing, then a bad command
      ready_mode = 0;
      run_line("/comment\n");
      run_line("\n");
      run_line("#0\n");
      run_line("t0\n");
      drain_and_compare("quiet");
      run_line("x\n");
      run_line("#2\n");
      do_reset();

      // stray transmit strobe
      tx_strobe = 1'b1;
      @(negedge clk);
      tx_strobe = 1'b0;
      #1;
      check_eq("stray_strobe_err", err, 1);
      do_reset();

      // saturation of the argument, reset mid-delay
      send_str("#65537\n");
      repeat (10) @(negedge clk);
      #1;
      check_eq("sat_busy", busy, 1);
      do_reset();
      send_str("#99999\n");
      begin
         int w = 0;
         #1;
         while (busy && w < 300) begin
            @(negedge clk);
            #1;
            w++;
         end
         check_eq("sat_long_busy", w, 300);
      end
      do_reset();
      #1;
      check_eq("midreset_state", {busy, err, in_ready}, 3'b001);
      @(negedge clk);

      // random lines
      for (int i = 0; i < 80; i++) begin
         run_line(rand_line());
         if (i % 10 == 9) begin
            drain_and_compare("rand");
            if ($urandom_range(0, 2) == 0) do_reset();
         end
      end
      drain_and_compare("final");

      send_byte("q");
      #1;
      check_eq("final_quit", {done, in_ready, busy}, 3'b100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cmd_stream_decoder.md
Name: cmd_stream_decoder

Overview:
- Synthesisable consumer of the line-oriented simulation control stream (byte-per-char, same command alphabet as the file-driven harness: '/', 'r', 't', '#', 'q').
- Sits between the byte source (FIFO/UART receive path) and the CPU's UART receive port.
- Forwards 'r' payloads to the CPU, stalls on 't' until the CPU has transmitted N chars, and stalls on '#' for N clocks.
- Raises done on 'q'.

Parameters:
CNT_WIDTH, 16, width of decimal argument accumulator and wait counters
RX_APPEND_NL, 0, 1 = forward the terminating '\n' of an 'r' line to rx port

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
in_data  in  8  command stream byte
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
rx_data  out  8  byte to CPU UART receive
rx_valid  out  1  rx_data valid (registered)
rx_ready  in  1  CPU consumes rx byte when rx_valid && rx_ready
tx_strobe  in  1  one-cycle pulse per char transmitted by CPU
busy  out  1  high in TX_WAIT or DELAY
done  out  1  sticky, high in QUIT
err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset: state=IDLE, rx_valid=0, rx_data=0, acc=0, cnt=0, done=0, err=0, busy=0. Reset mid-operation aborts everything and drops any pending rx byte.
- '\r' is accepted and discarded in every state that accepts input.
- IDLE (in_ready=1), next state on the accepted byte:
  - '/' -> COMMENT.
  - 'r' -> RX_PASS.
  - 't' or '#' -> NUM; latch the command and clear acc.
  - 'q' -> QUIT.
  - '\n' -> stay in IDLE (blank line).
  - Any other byte -> err=1, COMMENT.
- COMMENT (in_ready=1): discard bytes; '\n' -> IDLE.
- RX_PASS:
  - in_ready = !rx_valid || rx_ready. Registered output stage with one-byte holding, full throughput.
  - Accepted non-'\n' byte: rx_data<=byte, rx_valid<=1 the next cycle (latency 1).
  - Accepted '\n': forwarded as above only if RX_APPEND_NL=1; then -> IDLE.
  - rx_valid falls when consumed with no new load. rx_data is held stable while rx_valid && !rx_ready.
- NUM (in_ready=1):
  - Spaces are skipped.
  - Digits: acc <= acc*10 + digit, saturating at 2^CNT_WIDTH-1.
  - Any other byte except '\n' -> err=1, COMMENT (command aborted, no wait).
  - '\n' dispatch: cnt<=acc. If acc==0 -> IDLE, otherwise 't' -> TX_WAIT and '#' -> DELAY.
- TX_WAIT (in_ready=0, busy=1):
  - Each tx_strobe decrements cnt.
  - On the strobe that takes cnt 1->0, -> IDLE the next cycle.
- DELAY (in_ready=0, busy=1):
  - cnt decrements every cycle; exit when it reaches 0.
  - If '\n' is accepted in cycle k, busy is high in cycles k+1..k+N, and IDLE with in_ready=1 in cycle k+N+1.
- QUIT: in_ready=0, done=1, absorbing until reset. Any residual rx byte still drains normally.
- tx_strobe in any state other than TX_WAIT: ignored, err=1.
- rx_valid may remain high after leaving RX_PASS until the CPU consumes the byte.
  - A new 'r' line waits on the holding register via the in_ready rule.
  - 't'/'#' processing does not wait for the drain.

Test Plan:
- Stream "rHI\n" with rx_ready=1 → 'H', 'I' appear on rx with rx_valid one cycle after acceptance each. No '\n' appears (RX_APPEND_NL=0). State returns to IDLE.
- "rAB\n" with rx_ready held 0 for 5 cycles → rx_data='A' stable and in_ready=0 until rx_ready rises. Then 'B' follows and nothing is lost.
- "#5\n" accepted at cycle k → busy high cycles k+1..k+5. The next byte ("q") is accepted at k+6 and done=1 the following cycle.
- "t 3\n" then 2 tx_strobes → busy stays high. The 3rd strobe → busy=0 next cycle, in_ready=1.
- "/comment\n", "\n", "#0\n", "t0\n" → no rx output, busy never asserted, err=0. "x\n" → err=1 and the decoder resumes at IDLE.
- "#99999\n" with CNT_WIDTH=16 → saturates to 65535 cycles. Assert reset mid-DELAY → next cycle busy=0, err=0, in_ready=1.
